// File: rtl/ps2_pkg.sv
// Shared encodings for the PS/2 keyboard receiver: frame FSM states,
// scan-code prefixes/modifiers, output control codes and the parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  localparam logic [7:0] AS_CR    = 8'h0D;
  localparam logic [7:0] AS_BS    = 8'h08;
  localparam logic [7:0] AS_ESC   = 8'h1B;
  localparam logic [7:0] AS_TAB   = 8'h09;
  localparam logic [7:0] AS_UP    = 8'h11;
  localparam logic [7:0] AS_DOWN  = 8'h12;
  localparam logic [7:0] AS_LEFT  = 8'h13;
  localparam logic [7:0] AS_RIGHT = 8'h14;
  localparam logic [7:0] AS_HOME  = 8'h15;
  localparam logic [7:0] AS_END   = 8'h16;
  localparam logic [7:0] AS_DEL   = 8'h7F;
  localparam logic [7:0] AS_NONE  = 8'h00;

  // True when data plus parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// Registered scan-code (set 2, US layout) to ASCII translation ROM.
// Output 00 means the key produces no character.
module ps2_scan2ascii
  import ps2_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  input  logic       caps,
  input  logic       ctrl,
  output logic [7:0] ascii
);

  logic [7:0]  w_letter;
  logic [15:0] w_sym;
  logic [7:0]  w_next;
  logic [7:0]  r_ascii;

  function automatic logic [7:0] letter_lc(input logic [7:0] c);
    case (c)
      8'h1C: return 8'h61;  8'h32: return 8'h62;  8'h21: return 8'h63;
      8'h23: return 8'h64;  8'h24: return 8'h65;  8'h2B: return 8'h66;
      8'h34: return 8'h67;  8'h33: return 8'h68;  8'h43: return 8'h69;
      8'h3B: return 8'h6A;  8'h42: return 8'h6B;  8'h4B: return 8'h6C;
      8'h3A: return 8'h6D;  8'h31: return 8'h6E;  8'h44: return 8'h6F;
      8'h4D: return 8'h70;  8'h15: return 8'h71;  8'h2D: return 8'h72;
      8'h1B: return 8'h73;  8'h2C: return 8'h74;  8'h3C: return 8'h75;
      8'h2A: return 8'h76;  8'h1D: return 8'h77;  8'h22: return 8'h78;
      8'h35: return 8'h79;  8'h1A: return 8'h7A;
      default: return AS_NONE;
    endcase
  endfunction

  // {unshifted glyph, shifted glyph}
  function automatic logic [15:0] sym_pair(input logic [7:0] c);
    case (c)
      8'h16: return 16'h3121;  8'h1E: return 16'h3240;  8'h26: return 16'h3323;
      8'h25: return 16'h3424;  8'h2E: return 16'h3525;  8'h36: return 16'h365E;
      8'h3D: return 16'h3726;  8'h3E: return 16'h382A;  8'h46: return 16'h3928;
      8'h45: return 16'h3029;  8'h0E: return 16'h607E;  8'h4E: return 16'h2D5F;
      8'h55: return 16'h3D2B;  8'h54: return 16'h5B7B;  8'h5B: return 16'h5D7D;
      8'h5D: return 16'h5C7C;  8'h4C: return 16'h3B3A;  8'h52: return 16'h2722;
      8'h41: return 16'h2C3C;  8'h49: return 16'h2E3E;  8'h4A: return 16'h2F3F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [7:0] fixed_map(input logic [7:0] c);
    case (c)
      8'h5A:   return AS_CR;
      8'h66:   return AS_BS;
      8'h76:   return AS_ESC;
      8'h0D:   return AS_TAB;
      8'h29:   return 8'h20;
      default: return AS_NONE;
    endcase
  endfunction

  function automatic logic [7:0] ext_map(input logic [7:0] c);
    case (c)
      8'h75:   return AS_UP;
      8'h72:   return AS_DOWN;
      8'h6B:   return AS_LEFT;
      8'h74:   return AS_RIGHT;
      8'h6C:   return AS_HOME;
      8'h69:   return AS_END;
      8'h71:   return AS_DEL;
      default: return AS_NONE;
    endcase
  endfunction

  always_comb begin
    w_letter = letter_lc(code);
    w_sym    = sym_pair(code);
    w_next   = AS_NONE;
    if (ext) begin
      w_next = ext_map(code);
    end else if (w_letter != AS_NONE) begin
      if (ctrl) begin
        w_next = w_letter & 8'h1F;
      end else if (shift ^ caps) begin
        w_next = w_letter & 8'hDF;
      end else begin
        w_next = w_letter;
      end
    end else if (w_sym != 16'h0000) begin
      w_next = shift ? w_sym[7:0] : w_sym[15:8];
    end else begin
      w_next = fixed_map(code);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ascii <= AS_NONE;
    end else begin
      r_ascii <= w_next;
    end
  end

  assign ascii = r_ascii;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: line synchroniser and glitch filter, 11-bit frame FSM
// with parity/stop/timeout checking, and prefix/modifier decoder feeding the ASCII ROM.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int TIMEOUT = 25000,
  parameter int FILTER  = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       kdone,
  output logic [7:0] ascii,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic              r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic [FILTER-1:0] r_hist;
  logic [FILTER:0]   w_hist_ext;
  logic              r_fclk, r_fclk_d;
  logic              w_strobe, w_bit, w_frame_ok;

  ps2_state_t        r_state;
  logic [2:0]        r_bitcnt;
  logic [7:0]        r_shreg;
  logic              r_par;
  logic [TW-1:0]     r_tmo;
  logic              r_err;

  logic              r_ext, r_brk, r_shift, r_ctrl, r_caps;
  logic              r_lookup, r_kdone;
  logic [7:0]        r_ascii;
  logic [7:0]        w_rom;

  assign w_hist_ext = {r_hist, r_clk_s2};
  assign w_strobe   = r_fclk_d & ~r_fclk;
  assign w_bit      = r_dat_s2;
  assign w_frame_ok = w_strobe && (r_state == ST_STOP) && odd_parity_ok(r_shreg, r_par) && w_bit;

  // The filtered clock only flips once the whole history window agrees.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
      r_hist   <= {FILTER{1'b1}};
      r_fclk   <= 1'b1;
      r_fclk_d <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_dat;
      r_dat_s2 <= r_dat_s1;
      r_hist   <= w_hist_ext[FILTER-1:0];
      if (r_hist == {FILTER{1'b0}}) begin
        r_fclk <= 1'b0;
      end else if (r_hist == {FILTER{1'b1}}) begin
        r_fclk <= 1'b1;
      end else begin
        r_fclk <= r_fclk;
      end
      r_fclk_d <= r_fclk;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_bitcnt <= 3'd0;
      r_shreg  <= 8'h00;
      r_par    <= 1'b0;
      r_tmo    <= {TW{1'b0}};
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_tmo <= {TW{1'b0}};
        if (w_strobe && !w_bit) begin
          r_state  <= ST_DATA;
          r_bitcnt <= 3'd0;
        end
      end else if (!w_strobe) begin
        if (r_tmo == TMO_LAST) begin
          r_state <= ST_IDLE;
          r_tmo   <= {TW{1'b0}};
          r_err   <= 1'b1;
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
      end else begin
        r_tmo <= {TW{1'b0}};
        case (r_state)
          ST_DATA: begin
            r_shreg  <= {w_bit, r_shreg[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            r_par   <= w_bit;
            r_state <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            r_err   <= !w_frame_ok;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // Prefix/modifier decode happens in the stop-strobe cycle so the ROM sees
  // the byte that same cycle; kdone follows the ROM register by one clock.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ext    <= 1'b0;
      r_brk    <= 1'b0;
      r_shift  <= 1'b0;
      r_ctrl   <= 1'b0;
      r_caps   <= 1'b0;
      r_lookup <= 1'b0;
      r_kdone  <= 1'b0;
      r_ascii  <= AS_NONE;
    end else begin
      r_lookup <= 1'b0;
      r_kdone  <= 1'b0;
      if (r_lookup && (w_rom != AS_NONE)) begin
        r_kdone <= 1'b1;
        r_ascii <= w_rom;
      end
      if (w_frame_ok) begin
        if (r_shreg == SC_EXT) begin
          r_ext <= 1'b1;
        end else if (r_shreg == SC_BRK) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if ((r_shreg == SC_LSHIFT || r_shreg == SC_RSHIFT) && !r_ext) begin
            r_shift <= !r_brk;
          end else if (r_shreg == SC_CTRL) begin
            r_ctrl <= !r_brk;
          end else if (r_shreg == SC_CAPS) begin
            r_caps <= r_brk ? r_caps : !r_caps;
          end else begin
            r_lookup <= !r_brk;
          end
        end
      end
    end
  end

  ps2_scan2ascii u_rom (
    .clock   (clock),
    .reset_n (reset_n),
    .code    (r_shreg),
    .ext     (r_ext),
    .shift   (r_shift),
    .caps    (r_caps),
    .ctrl    (r_ctrl),
    .ascii   (w_rom)
  );

  assign kdone = r_kdone;
  assign ascii = r_ascii;
  assign err   = r_err;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: table of PS/2 frames with expected
// kdone/err/ascii, plus hand-written timeout and mid-frame reset sequences.
module tb_ps2_keyboard;

  localparam int HALF = 16;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       kdone;
  logic       err;
  logic [7:0] ascii;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_kdone = 0;
  int n_err = 0;
  int strobe_cyc = -100;

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       bad_stop;
    int         exp_kd;
    int         exp_err;
    logic [7:0] exp_ascii;
  } vec_t;

  vec_t vecs[$];

  ps2_keyboard #(.TIMEOUT(25000), .FILTER(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .kdone   (kdone),
    .ascii   (ascii),
    .err     (err)
  );

  always #5 clock = ~clock;

  initial forever @(posedge clock) cyc++;

  // kdone must land exactly two clocks after the most recent bit strobe.
  initial forever begin
    @(negedge clock);
    if (dut.w_strobe === 1'b1) strobe_cyc = cyc;
    if (kdone === 1'b1) begin
      n_kdone++;
      tests++;
      if (cyc - strobe_cyc != 2) begin
        fails++;
        $display("FAIL kdone_latency: got %0d clocks after strobe, expected 2", cyc - strobe_cyc);
      end
    end
    if (err === 1'b1) n_err++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string nm, input int idx, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic p;
    p = ~^b;
    return {~bad_stop, p ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      tick(HALF);
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic add(input logic [7:0] c, input int kd, input logic [7:0] a);
    vecs.push_back('{c, 1'b0, 1'b0, kd, 0, a});
  endtask

  task automatic add_bad(input logic [7:0] c, input logic bp, input logic bs, input logic [7:0] a);
    vecs.push_back('{c, bp, bs, 0, 1, a});
  endtask

  initial begin
    int k0, e0;

    add(8'h1C, 1, 8'h61);
    add(8'h12, 0, 8'h61);  add(8'h1C, 1, 8'h41);
    add(8'hF0, 0, 8'h41);  add(8'h1C, 0, 8'h41);
    add(8'hF0, 0, 8'h41);  add(8'h12, 0, 8'h41);
    add(8'h1C, 1, 8'h61);
    add_bad(8'h1C, 1'b1, 1'b0, 8'h61);
    add(8'h29, 1, 8'h20);
    add(8'hE0, 0, 8'h20);  add(8'h75, 1, 8'h11);
    add(8'hE0, 0, 8'h11);  add(8'hF0, 0, 8'h11);  add(8'h75, 0, 8'h11);
    add(8'h58, 0, 8'h11);  add(8'h1C, 1, 8'h41);  add(8'h1C, 1, 8'h41);
    add(8'hF0, 0, 8'h41);  add(8'h58, 0, 8'h41);  add(8'h1C, 1, 8'h41);
    add(8'h12, 0, 8'h41);  add(8'h1C, 1, 8'h61);  add(8'h16, 1, 8'h21);
    add(8'hF0, 0, 8'h21);  add(8'h12, 0, 8'h21);  add(8'h16, 1, 8'h31);
    add(8'h58, 0, 8'h31);
    add(8'h14, 0, 8'h31);  add(8'h21, 1, 8'h03);
    add(8'hF0, 0, 8'h03);  add(8'h14, 0, 8'h03);  add(8'h21, 1, 8'h63);
    add(8'h5A, 1, 8'h0D);  add(8'h66, 1, 8'h08);
    add(8'h76, 1, 8'h1B);  add(8'h0D, 1, 8'h09);
    add(8'hE0, 0, 8'h09);  add(8'h6B, 1, 8'h13);
    add(8'hE0, 0, 8'h13);  add(8'h71, 1, 8'h7F);
    add(8'hE0, 0, 8'h7F);  add(8'h14, 0, 8'h7F);  add(8'h1C, 1, 8'h01);
    add(8'hE0, 0, 8'h01);  add(8'hF0, 0, 8'h01);  add(8'h14, 0, 8'h01);
    add(8'h1C, 1, 8'h61);
    add_bad(8'h1C, 1'b0, 1'b1, 8'h61);
    add(8'h4A, 1, 8'h2F);

    // Reset state
    tick(5);
    check("rst_kdone", 0, int'(kdone), 0);
    check("rst_err",   0, int'(err),   0);
    check("rst_ascii", 0, int'(ascii), 0);
    reset_n = 1'b1;
    tick(5);
    check("post_rst_ascii", 0, int'(ascii), 0);

    foreach (vecs[i]) begin
      k0 = n_kdone;
      e0 = n_err;
      send_bits(frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop), 11);
      tick(10);
      check("kdone_cnt", i, n_kdone - k0, vecs[i].exp_kd);
      check("err_cnt",   i, n_err - e0,   vecs[i].exp_err);
      check("ascii",     i, int'(ascii),  int'(vecs[i].exp_ascii));
    end

    // Partial frame (start + 4 data bits) then silence: timeout error
    k0 = n_kdone;
    e0 = n_err;
    send_bits(frame(8'h5A, 1'b0, 1'b0), 5);
    tick(24000);
    check("tmo_early_err", 0, n_err - e0, 0);
    tick(1100);
    check("tmo_err", 0, n_err - e0, 1);
    check("tmo_kdone", 0, n_kdone - k0, 0);
    send_bits(frame(8'h5A, 1'b0, 1'b0), 11);
    tick(10);
    check("tmo_next_kdone", 0, n_kdone - k0, 1);
    check("tmo_next_ascii", 0, int'(ascii), 8'h0D);

    // Shift held, reset mid-frame, then 1C must come out lowercase
    k0 = n_kdone;
    e0 = n_err;
    send_bits(frame(8'h12, 1'b0, 1'b0), 11);
    send_bits(frame(8'h1C, 1'b0, 1'b0), 3);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(5);
    check("midrst_ascii", 0, int'(ascii), 0);
    send_bits(frame(8'h1C, 1'b0, 1'b0), 11);
    tick(10);
    check("midrst_kdone", 0, n_kdone - k0, 1);
    check("midrst_ascii", 1, int'(ascii), 8'h61);
    check("midrst_err",   0, n_err - e0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
